// File: rtl/mem_mem_log_pkg.sv
// mem_pkg: shared types for the MEM-stage trace logger.
//   mem_ctrl_t   - data-memory control bundle (memRead, memWrite, size, sign)
//   log_entry_t  - one trace-buffer entry as stored in the circular buffer
//   SZ_*/KIND_*  - size and entry-kind encodings
//   is_misaligned - alignment rule for a given size/address pair
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] KIND_RD = 2'b01;
  localparam logic [1:0] KIND_WR = 2'b10;
  localparam logic [1:0] KIND_RW = 2'b11;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       sign;    // 1 = unsigned
  } mem_ctrl_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  size;
    logic        sign;
    logic        misaligned;
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  // Size 00 and the reserved 11 encoding can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] addr);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = addr[0];
    else if (size == SZ_WORD) mis = (addr[1:0] != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_mem_log_if.sv
// mem_mem_log_if: snoop bus and trace read port of the MEM-stage logger.
//   master modport - environment side: drives the snooped buses and i_pop,
//                    observes head/status/counter outputs.
//   slave modport  - logger side.
// DEPTH sizes o_count; CNT_W sizes the statistics counters.
interface mem_mem_log_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
);
  import mem_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]      i_memAddr;
  logic [31:0]      i_writeData;
  mem_ctrl_t        i_ctrlMEM;
  logic [31:0]      i_readData;
  logic             i_pop;
  logic             o_valid;
  logic [1:0]       o_kind;
  logic [1:0]       o_size;
  logic             o_sign;
  logic             o_misaligned;
  logic [31:0]      o_addr;
  logic [31:0]      o_data;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic [CNT_W-1:0] o_readCount;
  logic [CNT_W-1:0] o_writeCount;
  logic [CNT_W-1:0] o_misalignCount;

  modport master (
    output i_memAddr, i_writeData, i_ctrlMEM, i_readData, i_pop,
    input  o_valid, o_kind, o_size, o_sign, o_misaligned, o_addr, o_data,
           o_count, o_overflow, o_readCount, o_writeCount, o_misalignCount
  );

  modport slave (
    input  i_memAddr, i_writeData, i_ctrlMEM, i_readData, i_pop,
    output o_valid, o_kind, o_size, o_sign, o_misaligned, o_addr, o_data,
           o_count, o_overflow, o_readCount, o_writeCount, o_misalignCount
  );

endinterface

// File: rtl/mem_mem_log_fifo.sv
// mem_log_fifo: circular buffer with overwrite-on-full.
//   i_clk, i_reset_n - clock, synchronous active-low reset (control only)
//   i_push, i_data   - write one W-bit entry
//   i_pop            - consume the oldest entry (ignored when empty)
//   o_data, o_valid  - oldest entry (zero while empty), non-empty flag
//   o_count          - entries held, 0..DEPTH
//   o_overflow       - sticky: an entry was overwritten
module mem_log_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop_eff;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_eff = i_pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (i_push) wr_d = wr_q + AW'(1);
    // Full and not popping: the oldest slot is about to be overwritten
    // (wr == rd), so the read pointer must step past it.
    if (i_push && full && !pop_eff) begin
      rd_d  = rd_q + AW'(1);
      ovf_d = 1'b1;
    end else if (pop_eff) begin
      rd_d = rd_q + AW'(1);
    end
    if (i_push && !pop_eff && !full) cnt_d = cnt_q + CW'(1);
    else if (!i_push && pop_eff)     cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage carries no reset; o_valid gates what is visible.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && i_push) mem_q[wr_q] <= i_data;
  end

  assign o_valid    = !empty;
  assign o_data     = empty ? '0 : mem_q[rd_q];
  assign o_count    = cnt_q;
  assign o_overflow = ovf_q;

endmodule

// File: rtl/mem_mem_log.sv
// mem_mem_log: MEM-stage data-memory trace logger (observes only).
//   i_clk, i_reset_n - clock, synchronous active-low reset
//   bus (slave)      - snooped address/write-data/control/read-data, i_pop,
//                      head entry fields, o_count, o_overflow, counters
// Every cycle with memRead|memWrite captures one entry into a DEPTH-deep
// circular buffer (oldest overwritten when full). Read/write/misalignment
// counters wrap at 2^CNT_W.
// Optional: define MEMLOG_DISPLAY_EN for simulation-only capture/overflow
// messages.
module mem_mem_log
  import mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input logic          i_clk,
  input logic          i_reset_n,
  mem_mem_log_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  mem_ctrl_t        ctrl;
  logic             capture;
  log_entry_t       entry_d, head;
  logic [CW-1:0]    count;
  logic             valid, overflow;
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q, mis_cnt_q;

  assign ctrl    = bus.i_ctrlMEM;
  assign capture = ctrl.memRead | ctrl.memWrite;

  always_comb begin
    entry_d            = '0;
    entry_d.kind       = {ctrl.memWrite, ctrl.memRead};
    entry_d.size       = ctrl.size;
    entry_d.sign       = ctrl.sign;
    entry_d.misaligned = is_misaligned(ctrl.size, bus.i_memAddr);
    entry_d.addr       = bus.i_memAddr;
    entry_d.data       = ctrl.memWrite ? bus.i_writeData : bus.i_readData;
  end

  mem_log_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(log_entry_t))
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (capture),
    .i_pop     (bus.i_pop),
    .i_data    (entry_d),
    .o_data    (head),
    .o_valid   (valid),
    .o_count   (count),
    .o_overflow(overflow)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (ctrl.memRead)  rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (ctrl.memWrite) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (capture && entry_d.misaligned) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_valid         = valid;
  assign bus.o_kind          = head.kind;
  assign bus.o_size          = head.size;
  assign bus.o_sign          = head.sign;
  assign bus.o_misaligned    = head.misaligned;
  assign bus.o_addr          = head.addr;
  assign bus.o_data          = head.data;
  assign bus.o_count         = count;
  assign bus.o_overflow      = overflow;
  assign bus.o_readCount     = rd_cnt_q;
  assign bus.o_writeCount    = wr_cnt_q;
  assign bus.o_misalignCount = mis_cnt_q;

`ifdef MEMLOG_DISPLAY_EN
  logic ovf_seen_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ovf_seen_q <= 1'b0;
    end else begin
      if (capture)
        $display("[memlog] t=%0t %s size=%0d sign=%0d addr=%h data=%h", $time,
                 (entry_d.kind == KIND_RW) ? "BOTH" :
                 (entry_d.kind == KIND_WR) ? "STORE" : "LOAD",
                 entry_d.size, entry_d.sign, entry_d.addr, entry_d.data);
      if (overflow && !ovf_seen_q) begin
        $display("[memlog] t=%0t trace buffer overflow", $time);
        ovf_seen_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_mem_log.sv
module tb_mem_mem_log;
  import mem_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_mem_log_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mem_mem_log #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of entries, oldest at index 0.
  log_entry_t  mq[$];
  logic [31:0] m_rc, m_wc, m_mc;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    log_entry_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    chk("valid",      64'(bus.o_valid),         64'(mq.size() != 0));
    chk("count",      64'(bus.o_count),         64'(mq.size()));
    chk("overflow",   64'(bus.o_overflow),      64'(m_ovf));
    chk("readCount",  64'(bus.o_readCount),     64'(m_rc));
    chk("writeCount", 64'(bus.o_writeCount),    64'(m_wc));
    chk("misCount",   64'(bus.o_misalignCount), 64'(m_mc));
    chk("head_kind",  64'(bus.o_kind),          64'(h.kind));
    chk("head_size",  64'(bus.o_size),          64'(h.size));
    chk("head_sign",  64'(bus.o_sign),          64'(h.sign));
    chk("head_mis",   64'(bus.o_misaligned),    64'(h.misaligned));
    chk("head_addr",  64'(bus.o_addr),          64'(h.addr));
    chk("head_data",  64'(bus.o_data),          64'(h.data));
  endtask

  task automatic model_clear();
    mq.delete();
    m_rc  = '0;
    m_wc  = '0;
    m_mc  = '0;
    m_ovf = 1'b0;
  endtask

  // One clock of activity: drive, clock, update model, check.
  task automatic step(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rdd,
                      input logic pop);
    log_entry_t e;
    bus.i_ctrlMEM.memRead  = rd;
    bus.i_ctrlMEM.memWrite = wr;
    bus.i_ctrlMEM.size     = sz;
    bus.i_ctrlMEM.sign     = sg;
    bus.i_memAddr          = addr;
    bus.i_writeData        = wd;
    bus.i_readData         = rdd;
    bus.i_pop              = pop;
    @(posedge clk);
    if (pop && mq.size() != 0) void'(mq.pop_front());
    if (rd || wr) begin
      e.kind       = {wr, rd};
      e.size       = sz;
      e.sign       = sg;
      e.misaligned = ((sz == 2'd1) && (addr % 2 != 0)) ||
                     ((sz == 2'd2) && (addr % 4 != 0));
      e.addr       = addr;
      e.data       = wr ? wd : rdd;
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1'b1;
      end
      mq.push_back(e);
      if (e.misaligned) m_mc = m_mc + 1;
    end
    if (rd) m_rc = m_rc + 1;
    if (wr) m_wc = m_wc + 1;
    #1;
    check_all();
  endtask

  // Reset asserted for one edge while the bus is busy.
  task automatic do_reset();
    rst_n                  = 1'b0;
    bus.i_ctrlMEM.memRead  = 1'b1;
    bus.i_ctrlMEM.memWrite = 1'b1;
    bus.i_ctrlMEM.size     = 2'b01;
    bus.i_ctrlMEM.sign     = 1'b0;
    bus.i_memAddr          = 32'h0000_0001;
    bus.i_writeData        = 32'h5555_AAAA;
    bus.i_readData         = 32'h1234_5678;
    bus.i_pop              = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_ctrlMEM = '0;
    bus.i_memAddr = '0;
    bus.i_writeData = '0;
    bus.i_readData  = '0;
    bus.i_pop       = 1'b0;
    model_clear();

    // Reset, then idle with a pop on an empty buffer.
    do_reset();
    chk("rst_count", 64'(bus.o_count), 64'd0);
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1);
    chk("pop_empty_count", 64'(bus.o_count), 64'd0);

    // Store word.
    step(0, 1, SZ_WORD, 0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    chk("st_kind",  64'(bus.o_kind),       64'h2);
    chk("st_size",  64'(bus.o_size),       64'h2);
    chk("st_addr",  64'(bus.o_addr),       64'h100);
    chk("st_data",  64'(bus.o_data),       64'hDEAD_BEEF);
    chk("st_wcnt",  64'(bus.o_writeCount), 64'd1);
    chk("st_mis",   64'(bus.o_misaligned), 64'd0);
    chk("st_count", 64'(bus.o_count),      64'd1);
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1);
    chk("st_pop_count", 64'(bus.o_count), 64'd0);

    // Misaligned half load.
    step(1, 0, SZ_HALF, 1, 32'h103, 32'hFFFF_0000, 32'h0000_FFFF, 0);
    chk("ld_kind", 64'(bus.o_kind),          64'h1);
    chk("ld_mis",  64'(bus.o_misaligned),    64'd1);
    chk("ld_mcnt", 64'(bus.o_misalignCount), 64'd1);
    chk("ld_data", 64'(bus.o_data),          64'h0000_FFFF);
    step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1);

    // Overflow: 17 stores into 16 slots, then drain.
    for (int i = 0; i < 17; i++)
      step(0, 1, SZ_WORD, 0, 32'(i), 32'(i), 32'h0, 0);
    chk("ovf_count", 64'(bus.o_count),    64'd16);
    chk("ovf_flag",  64'(bus.o_overflow), 64'd1);
    chk("ovf_head",  64'(bus.o_addr),     64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_addr", 64'(bus.o_addr), 64'(i + 1));
      step(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1);
    end
    chk("drained", 64'(bus.o_valid), 64'd0);

    // Full buffer with simultaneous capture and pop, overflow clear.
    do_reset();
    for (int i = 0; i < 16; i++)
      step(0, 1, SZ_BYTE, 0, 32'h200 + 32'(i), 32'(i), 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, SZ_BYTE, 1, 32'h300 + 32'(i), 32'hA0 + 32'(i), 32'h0, 1);
      chk("cp_count", 64'(bus.o_count),    64'd16);
      chk("cp_ovf",   64'(bus.o_overflow), 64'd0);
    end
    chk("cp_head", 64'(bus.o_addr), 64'h203);

    // Read and write in the same access.
    do_reset();
    step(1, 1, SZ_WORD, 0, 32'h40, 32'h12, 32'h99, 0);
    chk("rw_kind", 64'(bus.o_kind),       64'h3);
    chk("rw_data", 64'(bus.o_data),       64'h12);
    chk("rw_rcnt", 64'(bus.o_readCount),  64'd1);
    chk("rw_wcnt", 64'(bus.o_writeCount), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[31:4] = '0;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, $urandom, ($urandom_range(0, 4) < 2));
    end

    // Reset in the middle of activity.
    do_reset();
    step(0, 1, SZ_HALF, 0, 32'h2, 32'h77, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_mem_log.md
Name: mem_mem_log

Overview:
- Synchronous memory-access trace logger that sits beside the MEM-stage data memory and snoops its address, write data, control and read-data buses.
- Each access cycle captures one entry into a circular trace buffer. Entries are popped through a FIFO-style read port.
- Keeps per-type access counters and a misalignment count.
- Has no effect on the datapath.

Parameters:
- DEPTH, 16: number of trace entries; must be a power of two, at least 2.
- CNT_W, 32: width of each statistics counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_memAddr  in  32  byte address of the access.
- i_writeData  in  32  store data.
- i_ctrlMEM  in  mem_ctrl_t  fields memRead, memWrite, size[1:0] (00 byte, 01 half, 10 word), sign (1 = unsigned).
- i_readData  in  32  load data, already valid at the rising edge that ends the access cycle.
- i_pop  in  1  consume the oldest entry.
- o_valid  out  1  buffer non-empty.
- o_kind  out  2  oldest entry type: 01 read, 10 write, 11 read+write.
- o_size  out  2  oldest entry size.
- o_sign  out  1  oldest entry sign.
- o_misaligned  out  1  oldest entry was misaligned.
- o_addr  out  32  oldest entry address.
- o_data  out  32  oldest entry data.
- o_count  out  $clog2(DEPTH)+1  number of entries held.
- o_overflow  out  1  sticky flag: an entry was overwritten.
- o_readCount  out  CNT_W  total read accesses.
- o_writeCount  out  CNT_W  total write accesses.
- o_misalignCount  out  CNT_W  total misaligned accesses.

Behaviour:
- Reset (i_reset_n=0 at a rising edge):
  - pointers, o_count, o_overflow and all counters clear to 0; o_valid=0.
  - head fields read as 0 while the buffer is empty.
- Capture condition: memRead|memWrite at a rising edge.
  - Entry kind = {memWrite, memRead}.
  - Data = i_writeData if memWrite, else i_readData.
  - size and sign are copied unmodified; size=11 is logged as-is.
- Misaligned:
  - size=01 with addr[0]=1, or size=10 with addr[1:0]≠0.
  - size 00 and 11 are never misaligned.
- Latency: a captured entry is visible on the head outputs (if the buffer was empty) and in o_count on the following cycle.
- Head outputs are combinational from the read pointer and are valid only while o_valid=1.
- Pop when o_valid=1: advances the read pointer and decrements o_count. Pop when empty is ignored.
- Capture while full, no pop:
  - overwrites the oldest entry and advances both pointers;
  - o_count stays at DEPTH; o_overflow is set to 1.
- Capture and pop in the same cycle (non-empty): o_count is unchanged and no overflow occurs. When full, the popped entry is the one displaced.
- Capture and pop while empty: capture only; o_count becomes 1.
- Pointers wrap modulo DEPTH.
- Counters:
  - o_readCount increments when memRead=1; o_writeCount increments when memWrite=1; both increment when both are set.
  - o_misalignCount increments on each misaligned capture.
  - Counters wrap at 2^CNT_W.
- o_overflow clears only on reset.
- Reset asserted mid-operation takes precedence over capture and pop in that cycle.

Optional Feature:
- MEMLOG_DISPLAY_EN defined: on every capture, a simulation-only $display prints the time, kind (LOAD/STORE/BOTH), size, sign, address and data in hex. A second $display reports when an overflow first occurs.
- Not defined: no display statements are compiled; function is otherwise identical.

Decomposition:
- The shared package mem_pkg holds mem_ctrl_t, the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the kind encodings (KIND_RD/KIND_WR/KIND_RW).
- Sub-module mem_log_fifo: a generic circular buffer with overwrite-on-full, parameterised by DEPTH and entry width; it owns the pointers, o_count and overflow.
- The top level handles entry formation, misalignment detection, counters and the optional display.

Test Plan:
- Reset then idle: o_valid=0, o_count=0, all counters 0; a pop while empty leaves o_count=0.
- Store word 0xDEADBEEF at 0x100, then pop next cycle: o_kind=10, o_size=10, o_addr=0x100, o_data=0xDEADBEEF, o_writeCount=1, o_misaligned=0; o_count 1→0.
- Load half at 0x103 with i_readData=0x0000FFFF: o_kind=01, o_misaligned=1, o_misalignCount=1, o_data=0x0000FFFF.
- 17 stores (addresses 0..16, data=address) with DEPTH=16 and no pops: o_count=16, o_overflow=1, head o_addr=1; 16 pops drain addresses 1..16 in order.
- Full buffer with simultaneous capture and pop for 3 cycles: o_count stays 16 and o_overflow stays 0 if it was clear before.
- memRead=memWrite=1 at 0x40 with write data 0x12: o_kind=11, o_data=0x12; o_readCount and o_writeCount both increment.
